// File: rtl/adder_drv_pkg.sv
// Shared types, constants and helpers for the adder stimulus driver.
package adder_drv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DRIVE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } drv_state_t;

  // Right-shift Galois masks; the N=4 (8-bit) values are the ones used by default.
  localparam logic [7:0] LFSR_TAPS    = 8'hB8;
  localparam logic [7:0] DEFAULT_SEED = 8'h01;

  function automatic logic [31:0] lfsr_taps_f(input int w);
    logic [31:0] t;
    case (w)
      2:       t = 32'h0000_0003;
      4:       t = 32'h0000_000C;
      6:       t = 32'h0000_0030;
      8:       t = 32'h0000_00B8;
      10:      t = 32'h0000_0240;
      12:      t = 32'h0000_0829;
      14:      t = 32'h0000_2015;
      16:      t = 32'h0000_B400;
      32:      t = 32'h8020_0003;
      default: t = (32'h0000_0001 << (w - 1)) | 32'h0000_0001;
    endcase
    return t;
  endfunction

  function automatic logic [31:0] default_seed_f(input int w);
    logic [31:0] s;
    if (w > 0) begin
      s = 32'h0000_0001;
    end else begin
      s = 32'h0000_0000;
    end
    return s;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    logic [15:0] r;
    if (v == 16'hFFFF) begin
      r = v;
    end else begin
      r = v + 16'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/adder_drv_lfsr.sv
// Seedable Galois LFSR; a zero seed is replaced by SEED so the register never locks up.
module adder_drv_lfsr
  import adder_drv_pkg::*;
#(
  parameter int           W    = 8,
  parameter logic [W-1:0] TAPS = LFSR_TAPS,
  parameter logic [W-1:0] SEED = DEFAULT_SEED
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] seed_i,
  input  logic         step_i,
  output logic [W-1:0] state_o
);

  logic [W-1:0] lfsr_q, lfsr_d, next_s;

  always_comb begin
    if (lfsr_q[0]) begin
      next_s = {1'b0, lfsr_q[W-1:1]} ^ TAPS;
    end else begin
      next_s = {1'b0, lfsr_q[W-1:1]};
    end
    if (load_i) begin
      lfsr_d = (seed_i == {W{1'b0}}) ? SEED : seed_i;
    end else if (step_i) begin
      lfsr_d = next_s;
    end else begin
      lfsr_d = lfsr_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign state_o = lfsr_q;

endmodule

// File: rtl/adder_stim_driver.sv
// LFSR-driven self-checking stimulus source for an N-bit adder.
// Define ADDER_DRV_DIRECTED_EN to start every run with the four corner vectors.
module adder_stim_driver
  import adder_drv_pkg::*;
#(
  parameter int N       = 4,
  parameter int LATENCY = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [15:0]    num_vec,
  input  logic [2*N-1:0] seed,
  output logic [N-1:0]   in1,
  output logic [N-1:0]   in2,
  input  logic [N:0]     out,
  output logic           busy,
  output logic           done,
  output logic [15:0]    pass_cnt,
  output logic [15:0]    fail_cnt,
  output logic           fail_seen,
  output logic [N-1:0]   fail_in1,
  output logic [N-1:0]   fail_in2,
  output logic [N:0]     fail_out
);

  localparam int          W         = 2 * N;
  localparam logic [31:0] TAPS_FULL = lfsr_taps_f(W);
  localparam logic [31:0] SEED_FULL = default_seed_f(W);
  localparam logic [15:0] LAT_CNT   = 16'(LATENCY);

  drv_state_t     state_q, state_d;
  logic [N-1:0]   in1_q, in1_d, in2_q, in2_d;
  logic [N-1:0]   fin1_q, fin1_d, fin2_q, fin2_d;
  logic [N:0]     fout_q, fout_d, expected_s;
  logic           busy_q, busy_d, done_q, done_d, fseen_q, fseen_d;
  logic [15:0]    pass_q, pass_d, fail_q, fail_d, rem_q, rem_d, wcnt_q, wcnt_d;
  logic [W-1:0]   lfsr_s;
  logic           lfsr_load_s, lfsr_step_s;
`ifdef ADDER_DRV_DIRECTED_EN
  logic [2:0]     idx_q, idx_d;
`endif

  adder_drv_lfsr #(
    .W    (W),
    .TAPS (TAPS_FULL[W-1:0]),
    .SEED (SEED_FULL[W-1:0])
  ) u_lfsr (
    .clk_i   (clk),
    .rst_ni  (rst),
    .load_i  (lfsr_load_s),
    .seed_i  (seed),
    .step_i  (lfsr_step_s),
    .state_o (lfsr_s)
  );

  assign expected_s = {1'b0, in1_q} + {1'b0, in2_q};

  always_comb begin
    state_d     = state_q;
    in1_d       = in1_q;
    in2_d       = in2_q;
    fin1_d      = fin1_q;
    fin2_d      = fin2_q;
    fout_d      = fout_q;
    busy_d      = busy_q;
    done_d      = done_q;
    fseen_d     = fseen_q;
    pass_d      = pass_q;
    fail_d      = fail_q;
    rem_d       = rem_q;
    wcnt_d      = wcnt_q;
    lfsr_load_s = 1'b0;
    lfsr_step_s = 1'b0;
`ifdef ADDER_DRV_DIRECTED_EN
    idx_d       = idx_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          pass_d      = 16'd0;
          fail_d      = 16'd0;
          fseen_d     = 1'b0;
          fin1_d      = {N{1'b0}};
          fin2_d      = {N{1'b0}};
          fout_d      = {(N+1){1'b0}};
          rem_d       = num_vec;
          lfsr_load_s = 1'b1;
`ifdef ADDER_DRV_DIRECTED_EN
          idx_d       = 3'd0;
`endif
          // An empty run completes on the accepting edge itself.
          if (num_vec == 16'd0) begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = ST_DRIVE;
            busy_d  = 1'b1;
            done_d  = 1'b0;
          end
        end else begin
          state_d = state_q;
        end
      end
      ST_DRIVE: begin
        in1_d  = lfsr_s[N-1:0];
        in2_d  = lfsr_s[W-1:N];
`ifdef ADDER_DRV_DIRECTED_EN
        if (idx_q < 3'd4) begin
          case (idx_q[1:0])
            2'd0:    begin in1_d = {N{1'b0}}; in2_d = {N{1'b0}}; end
            2'd1:    begin in1_d = {N{1'b1}}; in2_d = {N{1'b1}}; end
            2'd2:    begin in1_d = {N{1'b1}}; in2_d = {N{1'b0}}; end
            default: begin in1_d = {N{1'b0}}; in2_d = {N{1'b1}}; end
          endcase
        end else begin
          in1_d = lfsr_s[N-1:0];
        end
`endif
        wcnt_d = LAT_CNT;
        if (LATENCY == 0) begin
          state_d = ST_CHECK;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        wcnt_d = wcnt_q - 16'd1;
        if (wcnt_q <= 16'd1) begin
          state_d = ST_CHECK;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_CHECK: begin
        if (out == expected_s) begin
          pass_d = sat_inc16(pass_q);
        end else begin
          fail_d = sat_inc16(fail_q);
          if (!fseen_q) begin
            fseen_d = 1'b1;
            fin1_d  = in1_q;
            fin2_d  = in2_q;
            fout_d  = out;
          end else begin
            fseen_d = fseen_q;
          end
        end
`ifdef ADDER_DRV_DIRECTED_EN
        lfsr_step_s = (idx_q >= 3'd4);
        idx_d       = (idx_q >= 3'd4) ? idx_q : idx_q + 3'd1;
`else
        lfsr_step_s = 1'b1;
`endif
        rem_d = rem_q - 16'd1;
        if (rem_q <= 16'd1) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = ST_DRIVE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      in1_q   <= {N{1'b0}};
      in2_q   <= {N{1'b0}};
      fin1_q  <= {N{1'b0}};
      fin2_q  <= {N{1'b0}};
      fout_q  <= {(N+1){1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fseen_q <= 1'b0;
      pass_q  <= 16'd0;
      fail_q  <= 16'd0;
      rem_q   <= 16'd0;
      wcnt_q  <= 16'd0;
`ifdef ADDER_DRV_DIRECTED_EN
      idx_q   <= 3'd0;
`endif
    end else begin
      state_q <= state_d;
      in1_q   <= in1_d;
      in2_q   <= in2_d;
      fin1_q  <= fin1_d;
      fin2_q  <= fin2_d;
      fout_q  <= fout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      fseen_q <= fseen_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      rem_q   <= rem_d;
      wcnt_q  <= wcnt_d;
`ifdef ADDER_DRV_DIRECTED_EN
      idx_q   <= idx_d;
`endif
    end
  end

  assign in1       = in1_q;
  assign in2       = in2_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass_cnt  = pass_q;
  assign fail_cnt  = fail_q;
  assign fail_seen = fseen_q;
  assign fail_in1  = fin1_q;
  assign fail_in2  = fin2_q;
  assign fail_out  = fout_q;

endmodule

// File: tb/tb_adder_stim_driver.sv
// Directed bench for adder_stim_driver: a LATENCY=0 and a LATENCY=2 instance,
// each paired with a bench adder model (the first can have its sum bit 0 stuck at 0).
module tb_adder_stim_driver;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Expected LFSR states written as {in2,in1}: seed A5 -> A5,EA,75,82; default seed 01 -> 01,B8,5C.
`ifdef ADDER_DRV_DIRECTED_EN
  localparam logic [7:0] EXP_A5 [0:3] = '{8'h00, 8'hFF, 8'h0F, 8'hF0};
  localparam logic [7:0] EXP_DEF [0:2] = '{8'h00, 8'hFF, 8'h0F};
  localparam logic [7:0] FIRST_FAIL = 8'h0F;
`else
  localparam logic [7:0] EXP_A5 [0:3] = '{8'hA5, 8'hEA, 8'h75, 8'h82};
  localparam logic [7:0] EXP_DEF [0:2] = '{8'h01, 8'hB8, 8'h5C};
  localparam logic [7:0] FIRST_FAIL = 8'hA5;
`endif

  logic        start0 = 1'b0, stuck0 = 1'b0;
  logic [15:0] nv0 = 16'd0;
  logic [7:0]  seed0 = 8'h00;
  logic [3:0]  a0, b0, fa0, fb0;
  logic [4:0]  out0, sum0, fo0;
  logic        busy0, done0, fseen0;
  logic [15:0] pass0, fail0;

  assign sum0 = {1'b0, a0} + {1'b0, b0};
  assign out0 = stuck0 ? (sum0 & 5'h1E) : sum0;

  logic        start2 = 1'b0;
  logic [15:0] nv2 = 16'd0;
  logic [7:0]  seed2 = 8'h00;
  logic [3:0]  a2, b2, fa2, fb2;
  logic [4:0]  p1 = 5'h00, p2 = 5'h00, fo2;
  logic        busy2, done2, fseen2;
  logic [15:0] pass2, fail2;

  always @(posedge clk) begin
    p1 <= {1'b0, a2} + {1'b0, b2};
    p2 <= p1;
  end

  adder_stim_driver #(.N(4), .LATENCY(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .num_vec(nv0), .seed(seed0),
    .in1(a0), .in2(b0), .out(out0), .busy(busy0), .done(done0),
    .pass_cnt(pass0), .fail_cnt(fail0), .fail_seen(fseen0),
    .fail_in1(fa0), .fail_in2(fb0), .fail_out(fo0)
  );

  adder_stim_driver #(.N(4), .LATENCY(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .num_vec(nv2), .seed(seed2),
    .in1(a2), .in2(b2), .out(p2), .busy(busy2), .done(done2),
    .pass_cnt(pass2), .fail_cnt(fail2), .fail_seen(fseen2),
    .fail_in1(fa2), .fail_in2(fb2), .fail_out(fo2)
  );

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "bench timed out");
  end

  task automatic go0(input logic [15:0] nv, input logic [7:0] sd);
    @(negedge clk); nv0 = nv; seed0 = sd; start0 = 1'b1;
    @(posedge clk); #1; start0 = 1'b0;
  endtask

  task automatic go2(input logic [15:0] nv, input logic [7:0] sd);
    @(negedge clk); nv2 = nv; seed2 = sd; start2 = 1'b1;
    @(posedge clk); #1; start2 = 1'b0;
  endtask

  // Counts edges from the accepting edge (counted as 1) until done0 is seen.
  task automatic wait_done0(inout int n);
    while (done0 !== 1'b1 && n < 2000) begin
      @(posedge clk); #1; n++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy0, done0, fseen0, busy2, done2, fseen2} !== 6'b0) begin
      errors++; $display("FAIL reset_flags got=%b want=000000", {busy0, done0, fseen0, busy2, done2, fseen2});
    end
    checks++;
    if ({pass0, fail0, pass2, fail2} !== 64'h0) begin
      errors++; $display("FAIL reset_counts got=%h want=0", {pass0, fail0, pass2, fail2});
    end
    checks++;
    if ({a0, b0, fa0, fb0, fo0, a2, b2, fa2, fb2, fo2} !== 42'h0) begin
      errors++; $display("FAIL reset_operands got=%h want=0", {a0, b0, fa0, fb0, fo0, a2, b2, fa2, fb2, fo2});
    end
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_lfsr_vectors;
    go0(16'd4, 8'hA5);
    checks++;
    if ({busy0, done0} !== 2'b10) begin
      errors++; $display("FAIL accept_busy got=%b want=10", {busy0, done0});
    end
    for (int v = 0; v < 4; v++) begin
      @(posedge clk); #1;
      checks++;
      if ({b0, a0} !== EXP_A5[v]) begin
        errors++; $display("FAIL vector%0d got=%h want=%h", v, {b0, a0}, EXP_A5[v]);
      end
      @(posedge clk); #1;
    end
    checks++;
    if ({busy0, done0} !== 2'b01 || pass0 !== 16'd4 || fail0 !== 16'd0) begin
      errors++; $display("FAIL vec4_end got=%b/%0d/%0d want=01/4/0", {busy0, done0}, pass0, fail0);
    end
    @(posedge clk); #1;
    checks++;
    if ({b0, a0} !== EXP_A5[3]) begin
      errors++; $display("FAIL done_hold got=%h want=%h", {b0, a0}, EXP_A5[3]);
    end
  endtask

  task automatic test_full_run;
    int n;
    go0(16'd100, 8'hA5);
    n = 1;
    wait_done0(n);
    checks++;
    if (n !== 201) begin
      errors++; $display("FAIL run100_cycles got=%0d want=201", n);
    end
    checks++;
    if (pass0 !== 16'd100 || fail0 !== 16'd0 || fseen0 !== 1'b0) begin
      errors++; $display("FAIL run100_counts got=%0d/%0d/%b want=100/0/0", pass0, fail0, fseen0);
    end
  endtask

  task automatic test_stuck_bit;
    int n;
    logic [4:0] fsum;
    stuck0 = 1'b1;
    go0(16'd50, 8'hA5);
    n = 1;
    wait_done0(n);
    stuck0 = 1'b0;
    fsum = {1'b0, fa0} + {1'b0, fb0};
    checks++;
    if (n !== 101 || ({1'b0, pass0} + {1'b0, fail0}) !== 17'd50) begin
      errors++; $display("FAIL stuck_total got=%0d cyc %0d vec want=101 cyc 50 vec", n, pass0 + fail0);
    end
    checks++;
    if (fail0 == 16'd0 || fseen0 !== 1'b1) begin
      errors++; $display("FAIL stuck_detect got=%0d/%b want=>0/1", fail0, fseen0);
    end
    checks++;
    if (fo0[0] !== 1'b0 || fsum[0] !== 1'b1) begin
      errors++; $display("FAIL stuck_parity got=%b/%b want=0/1", fo0[0], fsum[0]);
    end
    checks++;
    if ({fb0, fa0} !== FIRST_FAIL || fo0 !== 5'h0E) begin
      errors++; $display("FAIL stuck_first got=%h/%h want=%h/0e", {fb0, fa0}, fo0, FIRST_FAIL);
    end
  endtask

  task automatic test_zero_seed;
    int n;
    go0(16'd0, 8'h00);
    checks++;
    if ({busy0, done0, fseen0} !== 3'b010 || pass0 !== 16'd0 || fail0 !== 16'd0) begin
      errors++; $display("FAIL nv0 got=%b/%0d/%0d want=010/0/0", {busy0, done0, fseen0}, pass0, fail0);
    end
    go0(16'd3, 8'h00);
    checks++;
    if (done0 !== 1'b0) begin
      errors++; $display("FAIL done_clear got=%b want=0", done0);
    end
    for (int v = 0; v < 3; v++) begin
      @(posedge clk); #1;
      checks++;
      if ({b0, a0} !== EXP_DEF[v]) begin
        errors++; $display("FAIL defseed%0d got=%h want=%h", v, {b0, a0}, EXP_DEF[v]);
      end
      @(posedge clk); #1;
    end
    n = 7;
    wait_done0(n);
    checks++;
    if (n !== 7 || pass0 !== 16'd3) begin
      errors++; $display("FAIL defseed_end got=%0d/%0d want=7/3", n, pass0);
    end
  endtask

  task automatic test_latency2;
    go2(16'd3, 8'hA5);
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      checks++;
      if ({b2, a2} !== EXP_A5[(c - 1) / 4]) begin
        errors++; $display("FAIL lat2_op c%0d got=%h want=%h", c, {b2, a2}, EXP_A5[(c - 1) / 4]);
      end
      checks++;
      if (done2 !== (c == 12)) begin
        errors++; $display("FAIL lat2_done c%0d got=%b want=%b", c, done2, (c == 12));
      end
    end
    checks++;
    if (pass2 !== 16'd3 || fail2 !== 16'd0) begin
      errors++; $display("FAIL lat2_counts got=%0d/%0d want=3/0", pass2, fail2);
    end
  endtask

  task automatic test_start_ignored;
    int n;
    go0(16'd100, 8'hA5);
    n = 1;
    repeat (10) begin @(posedge clk); #1; n++; end
    @(negedge clk); nv0 = 16'd5; seed0 = 8'h00; start0 = 1'b1;
    @(posedge clk); #1; n++; start0 = 1'b0;
    checks++;
    if (busy0 !== 1'b1 || pass0 !== 16'd5) begin
      errors++; $display("FAIL ignored_start got=%b/%0d want=1/5", busy0, pass0);
    end
    wait_done0(n);
    checks++;
    if (n !== 201 || pass0 !== 16'd100) begin
      errors++; $display("FAIL ignored_end got=%0d/%0d want=201/100", n, pass0);
    end
  endtask

  task automatic test_reset_midrun;
    go0(16'd100, 8'hA5);
    repeat (39) @(posedge clk);
    #1;
    checks++;
    if (pass0 !== 16'd19 || busy0 !== 1'b1) begin
      errors++; $display("FAIL pre_abort got=%0d/%b want=19/1", pass0, busy0);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({busy0, done0, fseen0, done2} !== 4'b0 || {pass0, fail0} !== 32'h0 || {a0, b0} !== 8'h00) begin
      errors++; $display("FAIL abort got=%b/%h/%h want=0", {busy0, done0, fseen0, done2}, {pass0, fail0}, {a0, b0});
    end
    @(negedge clk); rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_lfsr_vectors();
    test_full_run();
    test_stuck_bit();
    test_zero_seed();
    test_latency2();
    test_start_ignored();
    test_reset_midrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
